execute_stage_muldiv: RTL and testbench

- Parametrised execute stage with ALU path, EX/MEM/WB operand forwarding and an iterative unsigned multiply/divide unit writing HI/LO.
- Sits between the ID/EX and EX/MEM pipeline registers and owns the EX/MEM register.
- Freezes the upstream pipeline, and inserts EX/MEM bubbles, while a multi-cycle op runs.

---
 rtl/execute_stage_muldiv.sv | 254 +++++++++++++++++++++++++
 tb/tb_execute_stage_muldiv.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_muldiv.sv
// Execute stage: ALU path with EX/MEM and MEM/WB operand forwarding, an
// iterative unsigned multiply/divide unit that owns HI/LO, and the EX/MEM
// pipeline register. A multi-cycle MULTU/DIVU freezes the upstream pipeline
// through ex_stall and feeds bubbles into EX/MEM until it retires.
module execute_stage_muldiv #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CU_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_ex_valid,
  input  logic [3:0]            id_ex_alu_ctrl,
  input  logic [2:0]            id_ex_md_op,
  input  logic                  id_ex_alusrc,
  input  logic                  id_ex_regdst,
  input  logic [CU_W-1:0]       id_ex_cu,
  input  logic [REG_ADDR_W-1:0] id_ex_rs,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic [DATA_W-1:0]     id_ex_rs_data,
  input  logic [DATA_W-1:0]     id_ex_rt_data,
  input  logic [DATA_W-1:0]     id_ex_imm,
  input  logic                  ex_mem_regwrite_fwd,
  input  logic                  mem_wb_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic [DATA_W-1:0]     mem_wb_data,
  output logic                  ex_stall,
  output logic                  ex_mem_valid,
  output logic [CU_W-1:0]       ex_mem_cu,
  output logic [DATA_W-1:0]     ex_mem_result,
  output logic [DATA_W-1:0]     ex_mem_wdata,
  output logic [REG_ADDR_W-1:0] ex_mem_waddr,
  output logic [DATA_W-1:0]     hi,
  output logic [DATA_W-1:0]     lo
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIVU  = 3'd2;
  localparam logic [2:0] MD_MFHI  = 3'd3;
  localparam logic [2:0] MD_MFLO  = 3'd4;

  // Single-cycle ALU; unknown control codes give zero, SLT compares signed.
  function automatic logic [DATA_W-1:0] alu_f(input logic [3:0] ctrl,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (ctrl)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_SLT: r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = {DATA_W{1'b0}};
    endcase
    return r;
  endfunction

  // Forwarding source: EX/MEM beats MEM/WB, register $0 is never forwarded.
  function automatic logic [DATA_W-1:0] fwd_f(input logic [REG_ADDR_W-1:0] field,
                                              input logic [DATA_W-1:0] id_data,
                                              input logic [REG_ADDR_W-1:0] exm_addr,
                                              input logic [DATA_W-1:0] exm_data,
                                              input logic exm_we,
                                              input logic [REG_ADDR_W-1:0] wb_addr,
                                              input logic [DATA_W-1:0] wb_data,
                                              input logic wb_we);
    logic [DATA_W-1:0] r;
    if (exm_we && (exm_addr == field) && (field != {REG_ADDR_W{1'b0}})) begin
      r = exm_data;
    end else if (wb_we && (wb_addr == field) && (field != {REG_ADDR_W{1'b0}})) begin
      r = wb_data;
    end else begin
      r = id_data;
    end
    return r;
  endfunction

  // State registers
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;   // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [DATA_W-1:0]     opb_q, opb_d;   // multiplicand or divisor
  logic                  mul_q, mul_d;
  logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                  exm_valid_q, exm_valid_d;
  logic [CU_W-1:0]       exm_cu_q, exm_cu_d;
  logic [DATA_W-1:0]     exm_result_q, exm_result_d;
  logic [DATA_W-1:0]     exm_wdata_q, exm_wdata_d;
  logic [REG_ADDR_W-1:0] exm_waddr_q, exm_waddr_d;

  // Combinational signals
  logic [DATA_W-1:0]     fwd_a_s, fwd_b_s, alu_b_s, result_s;
  logic [REG_ADDR_W-1:0] waddr_s;
  logic                  md_start_s, stall_s;
  logic [DATA_W:0]       mul_sum_s, div_shift_s, div_diff_s;
  logic                  div_ge_s;
  logic [DATA_W-1:0]     div_rem_s;
  logic [2*DATA_W-1:0]   iter_s;

  // Operand forwarding, operand B mux, write address and result selection.
  always_comb begin
    fwd_a_s = fwd_f(id_ex_rs, id_ex_rs_data, exm_waddr_q, exm_result_q,
                    ex_mem_regwrite_fwd, mem_wb_rd, mem_wb_data, mem_wb_regwrite);
    fwd_b_s = fwd_f(id_ex_rt, id_ex_rt_data, exm_waddr_q, exm_result_q,
                    ex_mem_regwrite_fwd, mem_wb_rd, mem_wb_data, mem_wb_regwrite);
    alu_b_s = id_ex_alusrc ? id_ex_imm : fwd_b_s;
    waddr_s = id_ex_regdst ? id_ex_rd : id_ex_rt;
    case (id_ex_md_op)
      MD_MFHI: result_s = hi_q;
      MD_MFLO: result_s = lo_q;
      default: result_s = alu_f(id_ex_alu_ctrl, fwd_a_s, alu_b_s);
    endcase
  end

  // One shift-add multiply step or one restoring divide step.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
                  (acc_q[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});
    div_shift_s = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    div_diff_s  = div_shift_s - {1'b0, opb_q};
    div_ge_s    = (div_shift_s >= {1'b0, opb_q});
    div_rem_s   = div_ge_s ? div_diff_s[DATA_W-1:0] : div_shift_s[DATA_W-1:0];
    if (mul_q) begin
      iter_s = {mul_sum_s, acc_q[DATA_W-1:1]};
    end else begin
      iter_s = {div_rem_s, acc_q[DATA_W-2:0], div_ge_s};
    end
  end

  // Start detection and stall; the start term is gated so reset forces stall low.
  always_comb begin
    md_start_s = rst && (state_q == ST_IDLE) && id_ex_valid &&
                 ((id_ex_md_op == MD_MULTU) || (id_ex_md_op == MD_DIVU));
    stall_s    = md_start_s || (rst && (state_q == ST_BUSY));
  end

  // Multiply/divide FSM next state, iteration datapath and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    mul_d   = mul_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md_start_s) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(DATA_W);
          acc_d   = {{DATA_W{1'b0}}, fwd_a_s};
          opb_d   = fwd_b_s;
          mul_d   = (id_ex_md_op == MD_MULTU);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        acc_d = iter_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          hi_d    = iter_s[2*DATA_W-1:DATA_W];
          lo_d    = iter_s[DATA_W-1:0];
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // EX/MEM next value: bubble while stalled or empty, GPR write masked on MD retire.
  always_comb begin
    exm_valid_d  = 1'b0;
    exm_cu_d     = {CU_W{1'b0}};
    exm_result_d = {DATA_W{1'b0}};
    exm_wdata_d  = {DATA_W{1'b0}};
    exm_waddr_d  = {REG_ADDR_W{1'b0}};
    if (!stall_s && id_ex_valid) begin
      exm_valid_d  = 1'b1;
      exm_cu_d     = id_ex_cu;
      exm_result_d = result_s;
      exm_wdata_d  = fwd_b_s;
      exm_waddr_d  = waddr_s;
      if (state_q == ST_DONE) begin
        exm_cu_d[0] = 1'b0;
      end else begin
        exm_cu_d[0] = id_ex_cu[0];
      end
    end else begin
      exm_valid_d = 1'b0;
    end
  end

  // All state registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      acc_q        <= {(2*DATA_W){1'b0}};
      opb_q        <= {DATA_W{1'b0}};
      mul_q        <= 1'b0;
      hi_q         <= {DATA_W{1'b0}};
      lo_q         <= {DATA_W{1'b0}};
      exm_valid_q  <= 1'b0;
      exm_cu_q     <= {CU_W{1'b0}};
      exm_result_q <= {DATA_W{1'b0}};
      exm_wdata_q  <= {DATA_W{1'b0}};
      exm_waddr_q  <= {REG_ADDR_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      opb_q        <= opb_d;
      mul_q        <= mul_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      exm_valid_q  <= exm_valid_d;
      exm_cu_q     <= exm_cu_d;
      exm_result_q <= exm_result_d;
      exm_wdata_q  <= exm_wdata_d;
      exm_waddr_q  <= exm_waddr_d;
    end
  end

  assign ex_stall      = stall_s;
  assign ex_mem_valid  = exm_valid_q;
  assign ex_mem_cu     = exm_cu_q;
  assign ex_mem_result = exm_result_q;
  assign ex_mem_wdata  = exm_wdata_q;
  assign ex_mem_waddr  = exm_waddr_q;
  assign hi            = hi_q;
  assign lo            = lo_q;

endmodule

// File: tb/tb_execute_stage_muldiv.sv
// Directed bench for execute_stage_muldiv: reset, ALU ops, forwarding,
// MULTU/DIVU latency and results, MFHI/MFLO and reset during an iteration.
module tb_execute_stage_muldiv;

  logic        clk;
  logic        rst;
  logic        id_ex_valid;
  logic [3:0]  id_ex_alu_ctrl;
  logic [2:0]  id_ex_md_op;
  logic        id_ex_alusrc;
  logic        id_ex_regdst;
  logic [3:0]  id_ex_cu;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic        ex_mem_regwrite_fwd, mem_wb_regwrite;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic        ex_stall;
  logic        ex_mem_valid;
  logic [3:0]  ex_mem_cu;
  logic [31:0] ex_mem_result, ex_mem_wdata;
  logic [4:0]  ex_mem_waddr;
  logic [31:0] hi, lo;

  int tests_run;
  int tests_failed;

  execute_stage_muldiv #(.DATA_W(32), .REG_ADDR_W(5), .CU_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_ex_valid(id_ex_valid), .id_ex_alu_ctrl(id_ex_alu_ctrl), .id_ex_md_op(id_ex_md_op),
    .id_ex_alusrc(id_ex_alusrc), .id_ex_regdst(id_ex_regdst), .id_ex_cu(id_ex_cu),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
    .ex_mem_regwrite_fwd(ex_mem_regwrite_fwd), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .ex_stall(ex_stall), .ex_mem_valid(ex_mem_valid), .ex_mem_cu(ex_mem_cu),
    .ex_mem_result(ex_mem_result), .ex_mem_wdata(ex_mem_wdata), .ex_mem_waddr(ex_mem_waddr),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic instr(input logic v, input logic [3:0] alu, input logic [2:0] md,
                       input logic alusrc, input logic regdst, input logic [3:0] cu,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm);
    id_ex_valid = v;      id_ex_alu_ctrl = alu; id_ex_md_op = md;
    id_ex_alusrc = alusrc; id_ex_regdst = regdst; id_ex_cu = cu;
    id_ex_rs = rs; id_ex_rt = rt; id_ex_rd = rd;
    id_ex_rs_data = rsd; id_ex_rt_data = rtd; id_ex_imm = imm;
  endtask

  task automatic fwd(input logic exm_we, input logic wb_we, input logic [4:0] wb_rd,
                     input logic [31:0] wb_data);
    ex_mem_regwrite_fwd = exm_we; mem_wb_regwrite = wb_we;
    mem_wb_rd = wb_rd; mem_wb_data = wb_data;
  endtask

  // Caller is at a negedge with the MD instruction already driven; returns #1
  // after the first negedge where ex_stall is low, with the stall-cycle count.
  task automatic count_stall(output int n);
    n = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (!ex_stall) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    instr(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    fwd(1'b0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (ex_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %b exp 0", ex_stall); end
    tests_run++; if (ex_mem_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", ex_mem_valid); end
    tests_run++; if ({ex_mem_cu, ex_mem_result, ex_mem_wdata, ex_mem_waddr} !== 73'd0) begin tests_failed++; $display("FAIL reset_exmem got %h exp 0", {ex_mem_cu, ex_mem_result, ex_mem_wdata, ex_mem_waddr}); end
    tests_run++; if ({hi, lo} !== 64'd0) begin tests_failed++; $display("FAIL reset_hilo got %h exp 0", {hi, lo}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_alu;
    // SUB 3-5, rd=3
    @(negedge clk);
    instr(1'b1, 4'd6, 3'd0, 1'b0, 1'b1, 4'b0001, 5'd1, 5'd2, 5'd3, 32'd3, 32'd5, 32'd0);
    #1;
    tests_run++; if (ex_stall !== 1'b0) begin tests_failed++; $display("FAIL sub_stall got %b exp 0", ex_stall); end
    tests_run++; if (ex_mem_result === 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL sub_early got %h exp not fffffffe", ex_mem_result); end
    @(posedge clk); #1;
    tests_run++; if (ex_mem_result !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL sub_result got %h exp fffffffe", ex_mem_result); end
    tests_run++; if (ex_mem_waddr !== 5'd3 || ex_mem_valid !== 1'b1 || ex_mem_cu !== 4'b0001) begin tests_failed++; $display("FAIL sub_ctl got %0d/%b/%b exp 3/1/0001", ex_mem_waddr, ex_mem_valid, ex_mem_cu); end
    // SLT -1 < 1, regdst=0 -> waddr=rt
    @(negedge clk);
    instr(1'b1, 4'd7, 3'd0, 1'b0, 1'b0, 4'b0001, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd0);
    #1;
    tests_run++; if (ex_stall !== 1'b0) begin tests_failed++; $display("FAIL slt_stall got %b exp 0", ex_stall); end
    @(posedge clk); #1;
    tests_run++; if (ex_mem_result !== 32'd1) begin tests_failed++; $display("FAIL slt_result got %h exp 1", ex_mem_result); end
    tests_run++; if (ex_mem_waddr !== 5'd2) begin tests_failed++; $display("FAIL slt_waddr got %0d exp 2", ex_mem_waddr); end
    // SLT 1 < -1 is false
    @(negedge clk);
    instr(1'b1, 4'd7, 3'd0, 1'b0, 1'b0, 4'b0001, 5'd1, 5'd2, 5'd3, 32'd1, 32'hFFFF_FFFF, 32'd0);
    @(posedge clk); #1;
    tests_run++; if (ex_mem_result !== 32'd0) begin tests_failed++; $display("FAIL slt_false got %h exp 0", ex_mem_result); end
    // AND / OR with immediate
    @(negedge clk);
    instr(1'b1, 4'd0, 3'd0, 1'b1, 1'b0, 4'b0001, 5'd1, 5'd2, 5'd3, 32'hF0F0_1234, 32'd0, 32'h0FF0_00FF);
    @(posedge clk); #1;
    tests_run++; if (ex_mem_result !== 32'h00F0_0034) begin tests_failed++; $display("FAIL and_result got %h exp 00f00034", ex_mem_result); end
    @(negedge clk);
    instr(1'b1, 4'd1, 3'd0, 1'b1, 1'b0, 4'b0001, 5'd1, 5'd2, 5'd3, 32'hF0F0_1234, 32'd0, 32'h0FF0_00FF);
    @(posedge clk); #1;
    tests_run++; if (ex_mem_result !== 32'hFFF0_12FF) begin tests_failed++; $display("FAIL or_result got %h exp fff012ff", ex_mem_result); end
    // Undefined code 3 produces 0
    @(negedge clk);
    instr(1'b1, 4'd3, 3'd0, 1'b0, 1'b0, 4'b0001, 5'd1, 5'd2, 5'd3, 32'd7, 32'd9, 32'd0);
    @(posedge clk); #1;
    tests_run++; if (ex_mem_result !== 32'd0) begin tests_failed++; $display("FAIL undef_result got %h exp 0", ex_mem_result); end
    // id_ex_valid=0 loads a bubble
    @(negedge clk);
    instr(1'b0, 4'd2, 3'd0, 1'b0, 1'b1, 4'b0011, 5'd1, 5'd2, 5'd3, 32'd7, 32'd9, 32'd0);
    @(posedge clk); #1;
    tests_run++; if (ex_mem_valid !== 1'b0 || ex_mem_cu !== 4'd0 || ex_mem_result !== 32'd0) begin tests_failed++; $display("FAIL bubble got %b/%b/%h exp 0/0000/0", ex_mem_valid, ex_mem_cu, ex_mem_result); end
  endtask

  task automatic test_forwarding;
    // Producer: ADD 2+3 -> $4
    @(negedge clk);
    fwd(1'b0, 1'b0, 5'd0, 32'd0);
    instr(1'b1, 4'd2, 3'd0, 1'b0, 1'b1, 4'b0001, 5'd1, 5'd2, 5'd4, 32'd2, 32'd3, 32'd0);
    @(posedge clk);
    // Consumer: rs=$4 matches EX/MEM (5) and MEM/WB (9); EX/MEM wins
    @(negedge clk);
    fwd(1'b1, 1'b1, 5'd4, 32'd9);
    instr(1'b1, 4'd2, 3'd0, 1'b0, 1'b1, 4'b0001, 5'd4, 5'd6, 5'd7, 32'd100, 32'd7, 32'd0);
    @(posedge clk); #1;
    tests_run++; if (ex_mem_result !== 32'd12) begin tests_failed++; $display("FAIL fwd_exmem got %0d exp 12", ex_mem_result); end
    tests_run++; if (ex_mem_wdata !== 32'd7) begin tests_failed++; $display("FAIL fwd_exmem_wdata got %0d exp 7", ex_mem_wdata); end
    // Producer writes $0 with result 5
    @(negedge clk);
    fwd(1'b0, 1'b0, 5'd0, 32'd0);
    instr(1'b1, 4'd2, 3'd0, 1'b0, 1'b1, 4'b0001, 5'd1, 5'd2, 5'd0, 32'd2, 32'd3, 32'd0);
    @(posedge clk);
    // Both stages write $0, operands are $0: no forwarding, 20+7
    @(negedge clk);
    fwd(1'b1, 1'b1, 5'd0, 32'd9);
    instr(1'b1, 4'd2, 3'd0, 1'b0, 1'b1, 4'b0001, 5'd0, 5'd0, 5'd8, 32'd20, 32'd7, 32'd0);
    @(posedge clk); #1;
    tests_run++; if (ex_mem_result !== 32'd27) begin tests_failed++; $display("FAIL fwd_zero got %0d exp 27", ex_mem_result); end
    // MEM/WB only, both operands $6; B replaced by imm but store data is forwarded B
    @(negedge clk);
    fwd(1'b0, 1'b1, 5'd6, 32'd9);
    instr(1'b1, 4'd2, 3'd0, 1'b1, 1'b0, 4'b0010, 5'd6, 5'd6, 5'd3, 32'd1, 32'd2, 32'h10);
    @(posedge clk); #1;
    tests_run++; if (ex_mem_result !== 32'h19) begin tests_failed++; $display("FAIL fwd_memwb got %h exp 19", ex_mem_result); end
    tests_run++; if (ex_mem_wdata !== 32'd9 || ex_mem_waddr !== 5'd6) begin tests_failed++; $display("FAIL fwd_store got %0d/%0d exp 9/6", ex_mem_wdata, ex_mem_waddr); end
    @(negedge clk);
    fwd(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_multu;
    int n;
    int vcount;
    @(negedge clk);
    fwd(1'b0, 1'b0, 5'd0, 32'd0);
    instr(1'b1, 4'd0, 3'd1, 1'b0, 1'b1, 4'b0011, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 32'd2, 32'd0);
    count_stall(n);
    tests_run++; if (n !== 33) begin tests_failed++; $display("FAIL multu_stall got %0d exp 33", n); end
    tests_run++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL multu_hilo got %h_%h exp 00000001_fffffffe", hi, lo); end
    vcount = 0;
    @(posedge clk); #1;
    if (ex_mem_valid) vcount++;
    tests_run++; if (ex_mem_valid !== 1'b1 || ex_mem_cu !== 4'b0010) begin tests_failed++; $display("FAIL multu_retire got %b/%b exp 1/0010", ex_mem_valid, ex_mem_cu); end
    @(negedge clk);
    instr(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    if (ex_mem_valid) vcount++;
    tests_run++; if (vcount !== 1) begin tests_failed++; $display("FAIL multu_entries got %0d exp 1", vcount); end
  endtask

  task automatic test_divu_mf;
    int n;
    @(negedge clk);
    instr(1'b1, 4'd0, 3'd2, 1'b0, 1'b1, 4'b0001, 5'd1, 5'd2, 5'd3, 32'd100, 32'd7, 32'd0);
    count_stall(n);
    tests_run++; if (n !== 33) begin tests_failed++; $display("FAIL divu_stall got %0d exp 33", n); end
    tests_run++; if (lo !== 32'd14 || hi !== 32'd2) begin tests_failed++; $display("FAIL divu_hilo got hi=%0d lo=%0d exp 2/14", hi, lo); end
    @(posedge clk);
    // MFLO -> $8 back-to-back, then MFHI -> $9
    @(negedge clk);
    instr(1'b1, 4'd0, 3'd4, 1'b0, 1'b1, 4'b0001, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'd0);
    #1;
    tests_run++; if (ex_stall !== 1'b0) begin tests_failed++; $display("FAIL mflo_stall got %b exp 0", ex_stall); end
    @(posedge clk); #1;
    tests_run++; if (ex_mem_result !== 32'd14 || ex_mem_waddr !== 5'd8 || ex_mem_cu !== 4'b0001) begin tests_failed++; $display("FAIL mflo_result got %0d/%0d/%b exp 14/8/0001", ex_mem_result, ex_mem_waddr, ex_mem_cu); end
    @(negedge clk);
    instr(1'b1, 4'd0, 3'd3, 1'b0, 1'b1, 4'b0001, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0);
    #1;
    tests_run++; if (ex_stall !== 1'b0) begin tests_failed++; $display("FAIL mfhi_stall got %b exp 0", ex_stall); end
    @(posedge clk); #1;
    tests_run++; if (ex_mem_result !== 32'd2 || ex_mem_waddr !== 5'd9) begin tests_failed++; $display("FAIL mfhi_result got %0d/%0d exp 2/9", ex_mem_result, ex_mem_waddr); end
  endtask

  task automatic test_div_zero;
    int n;
    @(negedge clk);
    instr(1'b1, 4'd0, 3'd2, 1'b0, 1'b1, 4'b0001, 5'd1, 5'd2, 5'd3, 32'h1234, 32'd0, 32'd0);
    count_stall(n);
    tests_run++; if (n !== 33) begin tests_failed++; $display("FAIL divz_stall got %0d exp 33", n); end
    tests_run++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h0000_1234) begin tests_failed++; $display("FAIL divz_hilo got %h_%h exp 00001234_ffffffff", hi, lo); end
    @(posedge clk);
    @(negedge clk);
    instr(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    instr(1'b1, 4'd0, 3'd1, 1'b0, 1'b1, 4'b0001, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 32'd2, 32'd0);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests_run++; if (ex_stall !== 1'b0) begin tests_failed++; $display("FAIL rstmid_stall got %b exp 0", ex_stall); end
    tests_run++; if ({hi, lo} !== 64'd0) begin tests_failed++; $display("FAIL rstmid_hilo got %h exp 0", {hi, lo}); end
    tests_run++; if ({ex_mem_valid, ex_mem_cu, ex_mem_result, ex_mem_wdata, ex_mem_waddr} !== 74'd0) begin tests_failed++; $display("FAIL rstmid_exmem got %h exp 0", {ex_mem_valid, ex_mem_cu, ex_mem_result, ex_mem_wdata, ex_mem_waddr}); end
    instr(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    instr(1'b1, 4'd2, 3'd0, 1'b0, 1'b1, 4'b0001, 5'd1, 5'd2, 5'd5, 32'd1, 32'd1, 32'd0);
    @(posedge clk); #1;
    tests_run++; if (ex_mem_result !== 32'd2 || ex_mem_valid !== 1'b1 || ex_mem_waddr !== 5'd5) begin tests_failed++; $display("FAIL rstmid_add got %0d/%b/%0d exp 2/1/5", ex_mem_result, ex_mem_valid, ex_mem_waddr); end
    @(negedge clk);
    instr(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    tests_run++; if ({hi, lo} !== 64'd0 || ex_stall !== 1'b0) begin tests_failed++; $display("FAIL rstmid_aborted got %h/%b exp 0/0", {hi, lo}, ex_stall); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_alu();
    test_forwarding();
    test_multu();
    test_divu_mf();
    test_div_zero();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
